// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared constants and helpers for the AXI-Lite pipeline buffer.
//                Holds the AXI-Lite response codes and a constant clog2 used
//                to size FIFO pointers and outstanding-transaction counters.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_buffer_if
//  Description : AXI-Lite bus bundle (AR, R, AW, W, B channels).
//                modport master : view of the side that issues requests
//                modport slave  : view of the side that answers them
//  Ports       : none (signal bundle only)
//  Revision    : 1.0  initial release
// ============================================================================
interface axi_lite_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, input  arready,
        input  rvalid, rdata, rresp, output rready,
        output awvalid, awaddr, input  awready,
        output wvalid, wdata, input  wready,
        input  bvalid, bresp, output bready
    );

    modport slave (
        input  arvalid, araddr, output arready,
        output rvalid, rdata, rresp, input  rready,
        input  awvalid, awaddr, output awready,
        input  wvalid, wdata, output wready,
        output bvalid, bresp, input  bready
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with valid/ready
//                on both sides. Ready and valid derive only from the
//                registered occupancy count, never from the opposite side.
//  Ports       : clk_i, rst_i (async, active-low)
//                i_push_valid / o_push_ready / i_push_data : write side
//                o_pop_valid  / i_pop_ready  / o_pop_data  : read side
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo
    import axi_lite_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  i_push_valid,
    output logic                       o_push_ready,
    input  wire logic [DATA_WIDTH-1:0] i_push_data,
    output logic                       o_pop_valid,
    input  wire logic                  i_pop_ready,
    output logic [DATA_WIDTH-1:0]      o_pop_data
);
    localparam int                c_PTR_W = clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_DEPTH = (c_PTR_W + 1)'(DEPTH);

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Ready is forced low while reset is held so the bus sees an idle port.
    assign o_push_ready = rst_i & ~w_full;
    assign o_pop_valid  = ~w_empty;
    // Storage is not reset; masking keeps the data output at zero when idle.
    assign o_pop_data   = w_empty ? '0 : r_mem[r_rd_ptr];

    assign w_push = i_push_valid & o_push_ready;
    assign w_pop  = i_pop_ready & o_pop_valid;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end
endmodule
`default_nettype wire

// File: rtl/axi_lite_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_buffer
//  Description : AXI-Lite pipeline buffer. Each of the five channels passes
//                through its own FIFO; read and write requests accepted from
//                the master are limited to MAX_OUTSTANDING unanswered each.
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - asynchronous active-low reset
//                m_if   - toward the bus master (slave modport)
//                s_if   - toward the slave / interconnect (master modport)
//  Revision    : 1.0  initial release
// ============================================================================
module axi_lite_buffer
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    axi_lite_buffer_if.slave   m_if,
    axi_lite_buffer_if.master  s_if
);
    localparam int                  c_CNT_W = clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0]  c_MAX   = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0]    r_rd_cnt;
    logic [c_CNT_W-1:0]    r_wr_cnt;
    logic                  w_rd_room;
    logic                  w_wr_room;
    logic                  w_ar_fifo_ready;
    logic                  w_aw_fifo_ready;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_aw_hs;
    logic                  w_b_hs;
    logic [DATA_WIDTH+1:0] w_r_entry;

    assign w_rd_room = (r_rd_cnt < c_MAX);
    assign w_wr_room = (r_wr_cnt < c_MAX);

    assign m_if.arready = w_ar_fifo_ready & w_rd_room;
    assign m_if.awready = w_aw_fifo_ready & w_wr_room;

    assign w_ar_hs = m_if.arvalid & m_if.arready;
    assign w_r_hs  = m_if.rvalid  & m_if.rready;
    assign w_aw_hs = m_if.awvalid & m_if.awready;
    assign w_b_hs  = m_if.bvalid  & m_if.bready;

    // A response with a zero count would be a slave protocol error; hold at 0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_ar_hs && !w_r_hs)                      r_rd_cnt <= r_rd_cnt + c_ONE;
            else if (!w_ar_hs && w_r_hs && r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - c_ONE;
            if (w_aw_hs && !w_b_hs)                      r_wr_cnt <= r_wr_cnt + c_ONE;
            else if (!w_aw_hs && w_b_hs && r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - c_ONE;
        end
    end

    // The push valid is qualified by the outstanding limit so the FIFO only
    // stores requests that the master actually sees accepted.
    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(ADDR_WIDTH)) u_ar_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_push_valid(m_if.arvalid & w_rd_room), .o_push_ready(w_ar_fifo_ready),
        .i_push_data(m_if.araddr),
        .o_pop_valid(s_if.arvalid), .i_pop_ready(s_if.arready), .o_pop_data(s_if.araddr)
    );

    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH + 2)) u_r_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_push_valid(s_if.rvalid), .o_push_ready(s_if.rready),
        .i_push_data({s_if.rresp, s_if.rdata}),
        .o_pop_valid(m_if.rvalid), .i_pop_ready(m_if.rready), .o_pop_data(w_r_entry)
    );

    assign m_if.rresp = w_r_entry[DATA_WIDTH +: 2];
    assign m_if.rdata = w_r_entry[DATA_WIDTH-1:0];

    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(ADDR_WIDTH)) u_aw_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_push_valid(m_if.awvalid & w_wr_room), .o_push_ready(w_aw_fifo_ready),
        .i_push_data(m_if.awaddr),
        .o_pop_valid(s_if.awvalid), .i_pop_ready(s_if.awready), .o_pop_data(s_if.awaddr)
    );

    // Write data is not throttled by the outstanding-write count.
    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_w_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_push_valid(m_if.wvalid), .o_push_ready(m_if.wready),
        .i_push_data(m_if.wdata),
        .o_pop_valid(s_if.wvalid), .i_pop_ready(s_if.wready), .o_pop_data(s_if.wdata)
    );

    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(2)) u_b_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_push_valid(s_if.bvalid), .o_push_ready(s_if.bready),
        .i_push_data(s_if.bresp),
        .o_pop_valid(m_if.bvalid), .i_pop_ready(m_if.bready), .o_pop_data(m_if.bresp)
    );
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_buffer
//  Description : Scoreboard bench for axi_lite_buffer (DEPTH=4,
//                MAX_OUTSTANDING=4). Stimulus pushes expected transfers into
//                per-channel queues; monitors pop and compare on handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_lite_buffer;
    import axi_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    axi_lite_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_bus ();
    axi_lite_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

    axi_lite_buffer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .m_if(m_bus), .s_if(s_bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_s_ar [$];
    logic [31:0] q_s_aw [$];
    logic [31:0] q_s_w  [$];
    logic [33:0] q_m_r  [$];
    logic [1:0]  q_m_b  [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: actual 0x%0h, required no transfer", name, act);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [9:0] all_vr();
        return {m_bus.arready, m_bus.awready, m_bus.wready, m_bus.rvalid, m_bus.bvalid,
                s_bus.arvalid, s_bus.awvalid, s_bus.wvalid, s_bus.rready, s_bus.bready};
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (s_bus.arvalid && s_bus.arready) begin
                if (q_s_ar.size() == 0) unexpected("s_ar", 64'(s_bus.araddr));
                else check("s_ar_addr", 64'(s_bus.araddr), 64'(q_s_ar.pop_front()));
            end
            if (s_bus.awvalid && s_bus.awready) begin
                if (q_s_aw.size() == 0) unexpected("s_aw", 64'(s_bus.awaddr));
                else check("s_aw_addr", 64'(s_bus.awaddr), 64'(q_s_aw.pop_front()));
            end
            if (s_bus.wvalid && s_bus.wready) begin
                if (q_s_w.size() == 0) unexpected("s_w", 64'(s_bus.wdata));
                else check("s_w_data", 64'(s_bus.wdata), 64'(q_s_w.pop_front()));
            end
            if (m_bus.rvalid && m_bus.rready) begin
                if (q_m_r.size() == 0) unexpected("m_r", 64'({m_bus.rresp, m_bus.rdata}));
                else check("m_r_resp_data", 64'({m_bus.rresp, m_bus.rdata}), 64'(q_m_r.pop_front()));
            end
            if (m_bus.bvalid && m_bus.bready) begin
                if (q_m_b.size() == 0) unexpected("m_b", 64'(m_bus.bresp));
                else check("m_b_resp", 64'(m_bus.bresp), 64'(q_m_b.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n_acc, idx, first, last, nxfer, n_aw, n_w, n_saw, max_wr;
        logic [7:0] mask;

        m_bus.arvalid = 0; m_bus.araddr = '0; m_bus.rready = 0;
        m_bus.awvalid = 0; m_bus.awaddr = '0; m_bus.wvalid = 0;
        m_bus.wdata = '0; m_bus.bready = 0;
        s_bus.arready = 0; s_bus.rvalid = 0; s_bus.rdata = '0; s_bus.rresp = '0;
        s_bus.awready = 0; s_bus.wready = 0; s_bus.bvalid = 0; s_bus.bresp = '0;

        // Reset state
        #2 rst_i = 1'b0;
        #1;
        check("rst_valid_ready", 64'(all_vr()), 64'(0));
        check("rst_data", 64'({m_bus.rdata, s_bus.araddr}), 64'(0));
        tick(); tick();
        rst_i = 1'b1;
        #1;
        check("post_rst_readies", 64'({m_bus.arready, m_bus.awready, m_bus.wready,
                                       s_bus.rready, s_bus.bready}), 64'(5'b11111));

        // Single read
        s_bus.arready = 1;
        m_bus.araddr = 32'h1000; m_bus.arvalid = 1; q_s_ar.push_back(32'h1000);
        tick();
        m_bus.arvalid = 0;
        check("t1_s_arvalid_latency", 64'(s_bus.arvalid), 64'(1));
        tick();
        s_bus.rdata = 32'hDEADBEEF; s_bus.rresp = RESP_OKAY; s_bus.rvalid = 1;
        m_bus.rready = 1; q_m_r.push_back({RESP_OKAY, 32'hDEADBEEF});
        tick();
        s_bus.rvalid = 0;
        check("t1_m_rvalid_latency", 64'(m_bus.rvalid), 64'(1));
        tick();
        check("t1_rd_cnt", 64'(dut.r_rd_cnt), 64'(0));
        m_bus.rready = 0;

        // W back-pressure / full, then in-order drain without gaps
        s_bus.wready = 0; idx = 1; first = -1; last = -1; nxfer = 0; mask = '0;
        for (int c = 0; c < 16; c++) begin
            if (c == 6) s_bus.wready = 1;
            m_bus.wvalid = (idx <= 6);
            m_bus.wdata  = 32'(idx);
            if (c < 6) mask[c] = m_bus.wready;
            if (m_bus.wvalid && m_bus.wready) begin
                q_s_w.push_back(32'(idx));
                idx++;
            end
            if (s_bus.wvalid && s_bus.wready) begin
                if (first < 0) first = c;
                last = c;
                nxfer++;
            end
            tick();
        end
        m_bus.wvalid = 0;
        check("t3_wready_pattern", 64'(mask[5:0]), 64'(6'b001111));
        check("t3_slave_beats", 64'(nxfer), 64'(6));
        check("t3_no_gaps", 64'(last - first), 64'(5));

        // Simultaneous push/pop at occupancy 2 across pointer wrap
        s_bus.wready = 0; m_bus.wvalid = 1;
        m_bus.wdata = 32'hA0; q_s_w.push_back(32'hA0); tick();
        m_bus.wdata = 32'hA1; q_s_w.push_back(32'hA1); tick();
        s_bus.wready = 1;
        for (int c = 0; c < 10; c++) begin
            m_bus.wdata = 32'hA2 + 32'(c);
            q_s_w.push_back(32'hA2 + 32'(c));
            check("t5_occ_and_ready", 64'({m_bus.wready, dut.u_w_fifo.r_count}), 64'({1'b1, 3'd2}));
            tick();
        end
        m_bus.wvalid = 0;
        tick(); tick(); tick();
        check("t5_drained", 64'(dut.u_w_fifo.r_count), 64'(0));

        // Streaming AW/W, slave answers B in the same cycle as its AW
        s_bus.awready = 1; s_bus.wready = 1; m_bus.bready = 1;
        n_aw = 0; n_w = 0; n_saw = 0; max_wr = 0;
        for (int c = 0; c < 36; c++) begin
            m_bus.awvalid = (c < 32);
            m_bus.awaddr  = 32'h3000 + 32'(c * 4);
            m_bus.wvalid  = (c < 32);
            m_bus.wdata   = 32'h5000 + 32'(c);
            s_bus.bvalid  = s_bus.awvalid;
            s_bus.bresp   = (s_bus.awaddr == 32'h3014) ? RESP_SLVERR : RESP_OKAY;
            if (c == 1) check("t4_aw_latency", 64'(s_bus.awvalid), 64'(1));
            if (m_bus.awvalid && m_bus.awready) begin
                q_s_aw.push_back(m_bus.awaddr);
                q_m_b.push_back((n_aw == 5) ? RESP_SLVERR : RESP_OKAY);
                n_aw++;
            end
            if (m_bus.wvalid && m_bus.wready) begin
                q_s_w.push_back(m_bus.wdata);
                n_w++;
            end
            if (s_bus.awvalid && s_bus.awready) n_saw++;
            if (int'(dut.r_wr_cnt) > max_wr) max_wr = int'(dut.r_wr_cnt);
            tick();
        end
        s_bus.bvalid = 0; m_bus.awvalid = 0; m_bus.wvalid = 0;
        tick();
        check("t4_aw_accepted", 64'(n_aw), 64'(32));
        check("t4_w_accepted", 64'(n_w), 64'(32));
        check("t4_slave_aw", 64'(n_saw), 64'(32));
        check("t4_wr_cnt_over_2", 64'(max_wr > 2), 64'(0));
        check("t4_wr_cnt_final", 64'(dut.r_wr_cnt), 64'(0));

        // Outstanding read limit
        m_bus.rready = 0; s_bus.rvalid = 0; s_bus.arready = 1;
        n_acc = 0; mask = '0;
        for (int c = 0; c < 8; c++) begin
            m_bus.arvalid = 1;
            m_bus.araddr  = 32'h2000 + 32'(n_acc * 4);
            mask[c] = m_bus.arready;
            if (m_bus.arready) begin
                q_s_ar.push_back(m_bus.araddr);
                n_acc++;
            end
            tick();
        end
        m_bus.arvalid = 0;
        check("t2_accepted", 64'(n_acc), 64'(4));
        check("t2_arready_pattern", 64'(mask), 64'(8'h0F));
        check("t2_rd_cnt_full", 64'(dut.r_rd_cnt), 64'(4));
        s_bus.rdata = 32'h11; s_bus.rresp = RESP_OKAY; s_bus.rvalid = 1;
        m_bus.rready = 1; q_m_r.push_back({RESP_OKAY, 32'h11});
        tick();
        s_bus.rvalid = 0;
        check("t2_ar_still_blocked", 64'(m_bus.arready), 64'(0));
        tick();
        check("t2_ar_reopen", 64'(m_bus.arready), 64'(1));
        check("t2_rd_cnt_3", 64'(dut.r_rd_cnt), 64'(3));
        m_bus.rready = 0;

        // Async reset with 3 reads outstanding and a stale R queued
        s_bus.rdata = 32'hBAD; s_bus.rvalid = 1;
        tick();
        s_bus.rvalid = 0;
        check("t6_stale_present", 64'(m_bus.rvalid), 64'(1));
        #2 rst_i = 1'b0;
        #1;
        check("t6_async_vr_zero", 64'(all_vr()), 64'(0));
        check("t6_async_rdata_zero", 64'(m_bus.rdata), 64'(0));
        q_s_ar.delete(); q_m_r.delete();
        tick(); tick();
        rst_i = 1'b1;
        #1;
        check("t6_arready", 64'(m_bus.arready), 64'(1));
        check("t6_rd_cnt", 64'(dut.r_rd_cnt), 64'(0));
        tick();
        check("t6_no_stale_r", 64'(m_bus.rvalid), 64'(0));

        check("queues_empty", 64'(q_s_ar.size() + q_s_aw.size() + q_s_w.size()
                                  + q_m_r.size() + q_m_b.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
